// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin merge of N_CH lane-packed streams onto one AXI4-Stream master.
// A grant is held until the outgoing TLAST, which is forced after MAX_LEN words.
module stream_rr_arbiter #(
  parameter int N_CH    = 12,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 256
) (
  input  logic                     clk40,
  input  logic                     reset,
  input  logic [N_CH*DATA_W-1:0]   s_tdata,
  input  logic [N_CH-1:0]          s_tvalid,
  input  logic [N_CH-1:0]          s_tlast,
  output logic [N_CH-1:0]          s_tready,
  input  logic [N_CH-1:0]          ch_enable,
  output logic [DATA_W-1:0]        M_AXIS_TDATA,
  output logic                     M_AXIS_TVALID,
  output logic                     M_AXIS_TLAST,
  output logic [3:0]               M_AXIS_TUSER,
  input  logic                     M_AXIS_TREADY,
  output logic                     busy,
  output logic                     err_trunc
);
  localparam int CNT_W = $clog2(MAX_LEN) + 1;

  typedef enum logic {IDLE, PASS} state_e;

  state_e              state_q, state_d;
  logic [3:0]          grant_q, grant_d;
  logic [3:0]          last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [3:0]          tuser_q, tuser_d;
  logic                err_q, err_d;

  logic [N_CH-1:0]     cand;
  logic                found;
  logic [3:0]          sel;
  logic                g_valid, g_last;
  logic [DATA_W-1:0]   g_data;
  logic                out_ready, xfer, out_last;

  // Rotating search: the channel served last is visited last.
  always_comb begin
    cand  = s_tvalid & ch_enable;
    found = 1'b0;
    sel   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!found && cand[c] && (c == (int'(last_grant_q) + i) % N_CH)) begin
          found = 1'b1;
          sel   = 4'(c);
        end
      end
    end
  end

  always_comb begin
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = '0;
    s_tready = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (4'(c) == grant_q) begin
        g_valid = s_tvalid[c];
        g_last  = s_tlast[c];
        g_data  = s_tdata[c*DATA_W +: DATA_W];
      end
    end
    out_ready = !tvalid_q || M_AXIS_TREADY;
    for (int c = 0; c < N_CH; c++) begin
      s_tready[c] = (state_q == PASS) && (4'(c) == grant_q) && out_ready;
    end
    xfer     = (state_q == PASS) && g_valid && out_ready;
    out_last = g_last || (word_cnt_q == CNT_W'(MAX_LEN - 1));
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = sel;
          word_cnt_d = '0;
          state_d    = PASS;
        end
      end
      PASS: begin
        if (xfer) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (out_last) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
            err_d        = !g_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      tdata_d  = g_data;
      tuser_d  = grant_q;
      tlast_d  = out_last;
      tvalid_d = 1'b1;
    end else if (M_AXIS_TREADY) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 4'(N_CH - 1);
      word_cnt_q   <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      err_q        <= err_d;
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TUSER  = tuser_q;
  assign busy          = (state_q == PASS);
  assign err_trunc     = err_q;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: one instance with MAX_LEN=256, one with MAX_LEN=4
// for truncation; a select bit routes the shared source model to one of them.
module tb_stream_rr_arbiter;
  localparam int N = 12;
  localparam int W = 32;

  logic clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  logic           reset = 1'b1;
  logic [N*W-1:0] s_tdata = '0;
  logic [N-1:0]   s_tvalid = '0;
  logic [N-1:0]   s_tlast = '0;
  logic [N-1:0]   ch_enable = '1;
  logic           M_AXIS_TREADY = 1'b1;
  logic           sel1 = 1'b0;
  logic           m_ready = 1'b1;

  logic [N-1:0] v0, v1, r0_tready, r1_tready;
  logic [W-1:0] d0_tdata, d1_tdata;
  logic         d0_tvalid, d1_tvalid, d0_tlast, d1_tlast;
  logic [3:0]   d0_tuser, d1_tuser;
  logic         d0_busy, d1_busy, d0_err, d1_err;

  assign v0 = sel1 ? '0 : s_tvalid;
  assign v1 = sel1 ? s_tvalid : '0;

  stream_rr_arbiter #(.N_CH(N), .DATA_W(W), .MAX_LEN(256)) u_dut0 (
    .clk40(clk40), .reset(reset), .s_tdata(s_tdata), .s_tvalid(v0), .s_tlast(s_tlast),
    .s_tready(r0_tready), .ch_enable(ch_enable), .M_AXIS_TDATA(d0_tdata),
    .M_AXIS_TVALID(d0_tvalid), .M_AXIS_TLAST(d0_tlast), .M_AXIS_TUSER(d0_tuser),
    .M_AXIS_TREADY(M_AXIS_TREADY), .busy(d0_busy), .err_trunc(d0_err));

  stream_rr_arbiter #(.N_CH(N), .DATA_W(W), .MAX_LEN(4)) u_dut1 (
    .clk40(clk40), .reset(reset), .s_tdata(s_tdata), .s_tvalid(v1), .s_tlast(s_tlast),
    .s_tready(r1_tready), .ch_enable(ch_enable), .M_AXIS_TDATA(d1_tdata),
    .M_AXIS_TVALID(d1_tvalid), .M_AXIS_TLAST(d1_tlast), .M_AXIS_TUSER(d1_tuser),
    .M_AXIS_TREADY(M_AXIS_TREADY), .busy(d1_busy), .err_trunc(d1_err));

  logic [N-1:0] m_sready;
  logic [W-1:0] m_tdata;
  logic         m_tvalid, m_tlast, m_busy, m_err;
  logic [3:0]   m_tuser;
  assign m_sready = sel1 ? r1_tready : r0_tready;
  assign m_tdata  = sel1 ? d1_tdata  : d0_tdata;
  assign m_tvalid = sel1 ? d1_tvalid : d0_tvalid;
  assign m_tlast  = sel1 ? d1_tlast  : d0_tlast;
  assign m_tuser  = sel1 ? d1_tuser  : d0_tuser;
  assign m_busy   = sel1 ? d1_busy   : d0_busy;
  assign m_err    = sel1 ? d1_err    : d0_err;

  // source model: per-channel word FIFOs
  logic [W-1:0] sdat  [N][16];
  logic         slast [N][16];
  int           shead [N];
  int           stail [N];

  logic [W-1:0] od[$];
  logic [3:0]   ou[$];
  logic         ol[$];
  int           ocyc[$];

  logic [W-1:0] e_d [16];
  logic [3:0]   e_u [16];
  logic         e_l [16];
  int           e_n;

  int n_chk = 0, n_err = 0, cyc = 0;
  int errs, stall_cnt, onehot_viol = 0, rdy_viol = 0, stall_viol = 0;
  logic prev_stall;
  logic [W-1:0] prev_data;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int ch, input logic [W-1:0] d, input logic l);
    sdat[ch][stail[ch]]  = d;
    slast[ch][stail[ch]] = l;
    stail[ch]++;
  endtask

  task automatic ex(input logic [W-1:0] d, input logic [3:0] u, input logic l);
    e_d[e_n] = d;
    e_u[e_n] = u;
    e_l[e_n] = l;
    e_n++;
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk40);
    for (int c = 0; c < N; c++) begin
      if (shead[c] != stail[c]) begin
        s_tvalid[c]         = 1'b1;
        s_tdata[c*W +: W]   = sdat[c][shead[c]];
        s_tlast[c]          = slast[c][shead[c]];
      end else begin
        s_tvalid[c]         = 1'b0;
        s_tdata[c*W +: W]   = '0;
        s_tlast[c]          = 1'b0;
      end
    end
    M_AXIS_TREADY = m_ready;
    #1;
    if (!reset) begin
      if ($countones(m_sready) > 1) onehot_viol++;
      if (m_busy && ((|m_sready) != !(m_tvalid && !M_AXIS_TREADY))) rdy_viol++;
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data)) stall_viol++;
      if (m_tvalid && !M_AXIS_TREADY) stall_cnt++;
      prev_stall = m_tvalid && !M_AXIS_TREADY;
      prev_data  = m_tdata;
      if (m_err) errs++;
      if (m_tvalid && M_AXIS_TREADY) begin
        od.push_back(m_tdata);
        ou.push_back(m_tuser);
        ol.push_back(m_tlast);
        ocyc.push_back(cyc);
      end
    end
    acc = m_sready & s_tvalid;
    @(posedge clk40);
    for (int c = 0; c < N; c++) if (acc[c]) shead[c]++;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    for (int c = 0; c < N; c++) begin
      shead[c] = 0;
      stail[c] = 0;
    end
    od.delete(); ou.delete(); ol.delete(); ocyc.delete();
    e_n = 0; errs = 0; stall_cnt = 0; prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; m_ready = 1'b1; ch_enable = '1;
    clr();
    tick(); tick();
    reset = 1'b0;
    clr();
  endtask

  task automatic cmp_out(input string tag);
    chk_eq({tag, " count"}, 64'(od.size()), 64'(e_n));
    for (int i = 0; i < e_n && i < od.size(); i++) begin
      chk_eq($sformatf("%s data%0d", tag, i), 64'(od[i]), 64'(e_d[i]));
      chk_eq($sformatf("%s user%0d", tag, i), 64'(ou[i]), 64'(e_u[i]));
      chk_eq($sformatf("%s last%0d", tag, i), 64'(ol[i]), 64'(e_l[i]));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, " tvalid"}, 64'(m_tvalid), 64'(0));
    chk_eq({tag, " tlast"},  64'(m_tlast),  64'(0));
    chk_eq({tag, " tdata"},  64'(m_tdata),  64'(0));
    chk_eq({tag, " tuser"},  64'(m_tuser),  64'(0));
    chk_eq({tag, " sready"}, 64'(m_sready), 64'(0));
    chk_eq({tag, " busy"},   64'(m_busy),   64'(0));
    chk_eq({tag, " err"},    64'(m_err),    64'(0));
  endtask

  initial begin
    int t0;
    // reset state
    do_reset();
    #1;
    chk_reset_vals("reset");

    // single channel, 4-word packet on ch3
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 4; i++) push(3, 32'hA0 + i, i == 3);
    run(8);
    for (int i = 0; i < 4; i++) ex(32'hA0 + i, 4'd3, i == 3);
    cmp_out("single");
    if (ocyc.size() == 4) begin
      chk_eq("single latency", 64'(ocyc[0] - t0), 64'(2));
      chk_eq("single rate", 64'(ocyc[3] - ocyc[0]), 64'(3));
    end else begin
      chk_eq("single words seen", 64'(ocyc.size()), 64'(4));
    end

    // round robin ch0, ch5, ch11, then ch0 again
    do_reset();
    push(0, 32'h00, 1'b0); push(0, 32'h01, 1'b1);
    push(0, 32'h02, 1'b0); push(0, 32'h03, 1'b1);
    push(5, 32'h50, 1'b0); push(5, 32'h51, 1'b1);
    push(11, 32'hB0, 1'b0); push(11, 32'hB1, 1'b1);
    run(20);
    ex(32'h00, 4'd0, 1'b0);  ex(32'h01, 4'd0, 1'b1);
    ex(32'h50, 4'd5, 1'b0);  ex(32'h51, 4'd5, 1'b1);
    ex(32'hB0, 4'd11, 1'b0); ex(32'hB1, 4'd11, 1'b1);
    ex(32'h02, 4'd0, 1'b0);  ex(32'h03, 4'd0, 1'b1);
    cmp_out("rr");

    // backpressure on a 6-word packet from ch7
    do_reset();
    for (int i = 0; i < 6; i++) push(7, 32'h70 + i, i == 5);
    for (int i = 0; i < 16; i++) begin
      m_ready = (i == 3 || i == 4 || i == 7) ? 1'b0 : 1'b1;
      tick();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) ex(32'h70 + i, 4'd7, i == 5);
    cmp_out("bp");
    chk_eq("bp stall cycles", 64'(stall_cnt), 64'(3));
    chk_eq("bp no trunc", 64'(errs), 64'(0));

    // truncation at MAX_LEN=4, ch2 sends 6 words
    sel1 = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) push(2, 32'h20 + i, i == 5);
    run(16);
    for (int i = 0; i < 6; i++) ex(32'h20 + i, 4'd2, i == 3 || i == 5);
    cmp_out("trunc");
    chk_eq("trunc err pulses", 64'(errs), 64'(1));
    sel1 = 1'b0;

    // ch_enable[1] dropped mid-packet
    do_reset();
    for (int i = 0; i < 6; i++) push(1, 32'h10 + i, i == 3 || i == 5);
    run(2);
    ch_enable[1] = 1'b0;
    run(12);
    for (int i = 0; i < 4; i++) ex(32'h10 + i, 4'd1, i == 3);
    cmp_out("enable");
    #1;
    chk_eq("enable busy", 64'(m_busy), 64'(0));
    ch_enable = '1;

    // reset mid-packet, then ch0 has priority over ch4
    do_reset();
    for (int i = 0; i < 6; i++) push(4, 32'h40 + i, i == 5);
    run(3);
    m_ready = 1'b0;
    tick();
    chk_eq("rst pre words", 64'(od.size()), 64'(1));
    reset = 1'b1;
    tick();
    #1;
    chk_reset_vals("midrst");
    reset = 1'b0;
    m_ready = 1'b1;
    clr();
    push(4, 32'h46, 1'b0); push(4, 32'h47, 1'b1);
    push(0, 32'h0A, 1'b0); push(0, 32'h0B, 1'b1);
    run(12);
    ex(32'h0A, 4'd0, 1'b0); ex(32'h0B, 4'd0, 1'b1);
    ex(32'h46, 4'd4, 1'b0); ex(32'h47, 4'd4, 1'b1);
    cmp_out("postrst");

    chk_eq("sready onehot", 64'(onehot_viol), 64'(0));
    chk_eq("sready vs stall", 64'(rdy_viol), 64'(0));
    chk_eq("stall hold", 64'(stall_viol), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
